uart_tx_arbiter: RTL

Shares one UART TX line between NUM_REQ byte-stream requesters in the DV environment, e.g. several firmware or agent console sources feeding one DPI/pty UART.
- Round-robin, message-granular grant: a requester keeps the line until it ends its message or hits a burst limit.
- Contains its own 8N1 serializer timed in clock cycles per symbol.
- Its tx_o drives the rx input of the UART DPI model or the DUT.

---
 rtl/uart_tx_arbiter_pkg.sv | 9 +
 rtl/uart_tx_ser.sv | 68 ++++++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART TX arbiter and its serializer.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {IDLE, TAG, GRANT, START, DATA, STOP} state_e;

  localparam logic [7:0] TAG_PREFIX = 8'hF0;
  localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 serializer: one start bit, 8 data bits LSB first, one stop bit,
// each held CYCLES_PER_SYMBOL clocks. o_done marks the last stop-bit cycle.
module uart_tx_ser
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CYCLES_PER_SYMBOL = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_tx
);

  localparam int CNT_W = $clog2(CYCLES_PER_SYMBOL);

  state_e           r_st;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_sh;
  logic             w_sym_end;

  assign w_sym_end = (r_cnt == CNT_W'(CYCLES_PER_SYMBOL - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st  <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else if (i_load && r_st == IDLE) begin
      r_st  <= START;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= i_byte;
    end else if (r_st != IDLE) begin
      if (w_sym_end) begin
        r_cnt <= '0;
        case (r_st)
          START: r_st <= DATA;
          DATA: begin
            r_sh  <= r_sh >> 1;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_st <= STOP;
          end
          default: r_st <= IDLE;
        endcase
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (r_st)
      START:   o_tx = 1'b0;
      DATA:    o_tx = r_sh[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy = (r_st != IDLE);
  assign o_done = (r_st == STOP) && w_sym_end;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one 8N1 TX line among NUM_REQ sources.
// Define UART_TX_ARBITER_TAG_EN to prefix each new grant with a 0xF0|id tag frame.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int CYCLES_PER_SYMBOL = 16,
  parameter int MAX_BURST         = 64,
  parameter int ID_W              = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_o,
  output logic                 grant_valid_o,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 busy_o
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  state_e          r_state, w_state_nxt;
  logic            r_gvld;
  logic [ID_W-1:0] r_gid, r_rr, w_win;
  logic [BC_W-1:0] r_burst;
  logic            r_rel;

  logic            w_win_vld, w_hold_vld, w_hold_last, w_accept, w_release;
  logic [7:0]      w_hold_data, w_byte;
  logic            w_load, w_done, w_busy, w_tx;

  assign w_hold_vld  = req_valid_i[r_gid];
  assign w_hold_last = req_last_i[r_gid];
  assign w_hold_data = req_data_i[8*r_gid +: 8];
  assign w_accept    = (r_state == GRANT) && w_hold_vld;
  assign w_release   = ((r_state == GRANT) && !w_hold_vld) ||
                       ((r_state == START) && w_done && r_rel);

  // Scan downwards so the smallest offset from r_rr is the one left standing.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[(int'(r_rr) + k) % NUM_REQ]) begin
        w_win_vld = 1'b1;
        w_win     = ID_W'((int'(r_rr) + k) % NUM_REQ);
      end
    end
  end

`ifdef UART_TX_ARBITER_TAG_EN
  assign w_load = w_accept || ((r_state == IDLE) && w_win_vld);
  assign w_byte = w_accept ? w_hold_data : (TAG_PREFIX | 8'(w_win));
`else
  assign w_load = w_accept;
  assign w_byte = w_hold_data;
`endif

  // START here covers the whole data frame; the serializer walks START/DATA/STOP itself.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_win_vld) begin
`ifdef UART_TX_ARBITER_TAG_EN
        w_state_nxt = TAG;
`else
        w_state_nxt = GRANT;
`endif
      end
      TAG:     if (w_done) w_state_nxt = GRANT;
      GRANT:   w_state_nxt = w_hold_vld ? START : IDLE;
      START:   if (w_done) w_state_nxt = r_rel ? IDLE : GRANT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gvld  <= 1'b0;
      r_gid   <= '0;
      r_rr    <= '0;
      r_burst <= '0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) begin
        r_gvld  <= 1'b0;
        r_gid   <= '0;
        r_rr    <= (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
        r_burst <= '0;
        r_rel   <= 1'b0;
      end else if ((r_state == IDLE) && w_win_vld) begin
        r_gvld <= 1'b1;
        r_gid  <= w_win;
      end else if (w_accept) begin
        r_burst <= r_burst + 1'b1;
        r_rel   <= w_hold_last || (r_burst + 1'b1 == BC_W'(MAX_BURST));
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == GRANT) req_ready_o[r_gid] = 1'b1;
  end

  uart_tx_ser #(.CYCLES_PER_SYMBOL(CYCLES_PER_SYMBOL)) u_ser (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_byte (w_byte),
    .o_busy (w_busy),
    .o_done (w_done),
    .o_tx   (w_tx)
  );

  assign tx_o          = w_tx;
  assign busy_o        = w_busy;
  assign grant_valid_o = r_gvld;
  assign grant_id_o    = r_gid;

endmodule
